rf_wb_ctrl: RTL and testbench

- Write-back controller for the 32x32 register file: arbitrates two write-back sources (A = ALU, B = load/mem) onto the single RF write port (write_e / rd / write_d).
- Keeps a pending-write scoreboard so decode can detect RAW and WAW hazards against in-flight writes.
- Sits between execute/mem write-back and the RF.
- The RF write port is driven only by this block.

---
 rtl/rf_wb_ctrl_if.sv | 28 ++
 rtl/rf_wb_ctrl.sv | 91 +++++++++
 tb/tb_rf_wb_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_ctrl_if.sv
// Write-back bus for rf_wb_ctrl: two write-back sources (A = ALU, B = load/mem)
// and the single register-file write port.
interface rf_wb_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wd
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_we, rf_rd, rf_wd
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: round-robin arbitration of two sources onto
// the RF write port plus a pending-write scoreboard. Optional macro: RF_WB_BYPASS_EN.
module rf_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_ctrl_if.slave       wb,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              haz_rs1,
  output logic              haz_rs2,
  output logic              haz_rd,
  output logic [2**AW-1:0]  pend
`ifdef RF_WB_BYPASS_EN
  ,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data
`endif
);

  typedef enum logic {PREF_A = 1'b0, PREF_B = 1'b1} rr_t;

  rr_t             rr;
  logic            hs_a;
  logic            hs_b;
  logic            hs;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [2**AW-1:0] pend_n;

  // Readies are forced low during reset so nothing is accepted that reset would discard.
  assign wb.a_ready = ~rst & wb.a_valid & (~wb.b_valid | (rr == PREF_A));
  assign wb.b_ready = ~rst & wb.b_valid & (~wb.a_valid | (rr == PREF_B));

  always_comb begin
    hs_a     = wb.a_valid & wb.a_ready;
    hs_b     = wb.b_valid & wb.b_ready;
    hs       = hs_a | hs_b;
    sel_rd   = hs_a ? wb.a_rd   : wb.b_rd;
    sel_data = hs_a ? wb.a_data : wb.b_data;
    // Clear first, then set, so an issue to the same index in the same cycle wins.
    pend_n = pend;
    if (hs && (sel_rd != '0))
      pend_n[sel_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      pend_n[iss_rd] = 1'b1;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.rf_we <= 1'b0;
      wb.rf_rd <= '0;
      wb.rf_wd <= '0;
      pend     <= '0;
      rr       <= PREF_A;
    end else begin
      pend <= pend_n;
      if (hs) begin
        wb.rf_we <= (sel_rd != '0);
        wb.rf_rd <= sel_rd;
        wb.rf_wd <= sel_data;
        rr       <= hs_a ? PREF_B : PREF_A;
      end else begin
        wb.rf_we <= 1'b0;
      end
    end
  end

  assign haz_rd = iss_valid & (iss_rd != '0) & pend[iss_rd];

`ifdef RF_WB_BYPASS_EN
  assign fwd1_hit  = wb.rf_we & (wb.rf_rd == rs1) & (rs1 != '0);
  assign fwd2_hit  = wb.rf_we & (wb.rf_rd == rs2) & (rs2 != '0);
  assign fwd1_data = wb.rf_wd;
  assign fwd2_data = wb.rf_wd;
  assign haz_rs1   = (rs1 != '0) & pend[rs1];
  assign haz_rs2   = (rs2 != '0) & pend[rs2];
`else
  // The rf_we term covers the cycle where the write is on the port but not yet in the RF.
  assign haz_rs1 = (rs1 != '0) & (pend[rs1] | (wb.rf_we & (wb.rf_rd == rs1)));
  assign haz_rs2 = (rs2 != '0) & (pend[rs2] | (wb.rf_we & (wb.rf_rd == rs2)));
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed self-checking bench for rf_wb_ctrl; also covers RF_WB_BYPASS_EN when defined.
module tb_rf_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        haz_rs1, haz_rs2, haz_rd;
  logic [31:0] pend;
`ifdef RF_WB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif
  int n_cmp = 0;
  int n_err = 0;

  rf_wb_ctrl_if #(.XLEN(32), .AW(5)) wb ();

  rf_wb_ctrl #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .wb(wb),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .haz_rs1(haz_rs1), .haz_rs2(haz_rs2), .haz_rd(haz_rd), .pend(pend)
`ifdef RF_WB_BYPASS_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    wb.a_valid = 1'b0; wb.a_rd = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_rd = '0; wb.b_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(posedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; idle();
    wb.a_valid = 1'b1; wb.a_rd = 5'd1; wb.b_valid = 1'b1; wb.b_rd = 5'd2;
    #1;
    n_cmp++; if (wb.a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %b want 0", wb.a_ready); end
    n_cmp++; if (wb.b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready: got %b want 0", wb.b_ready); end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (wb.rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %b want 0", wb.rf_we); end
    n_cmp++; if (wb.rf_rd !== 5'd0) begin n_err++; $display("FAIL rst_rf_rd: got %0d want 0", wb.rf_rd); end
    n_cmp++; if (wb.rf_wd !== 32'd0) begin n_err++; $display("FAIL rst_rf_wd: got %h want 0", wb.rf_wd); end
    n_cmp++; if (pend !== 32'd0) begin n_err++; $display("FAIL rst_pend: got %h want 0", pend); end
    rst = 1'b0; idle();
  endtask

  task automatic test_single_write();
    @(negedge clk); wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 32'h1234;
    #1;
    n_cmp++; if (wb.a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready: got %b want 1", wb.a_ready); end
    n_cmp++; if (wb.b_ready !== 1'b0) begin n_err++; $display("FAIL single_b_ready: got %b want 0", wb.b_ready); end
    @(posedge clk); @(negedge clk); idle(); #1;
    n_cmp++; if (wb.rf_we !== 1'b1) begin n_err++; $display("FAIL single_rf_we: got %b want 1", wb.rf_we); end
    n_cmp++; if (wb.rf_rd !== 5'd5) begin n_err++; $display("FAIL single_rf_rd: got %0d want 5", wb.rf_rd); end
    n_cmp++; if (wb.rf_wd !== 32'h1234) begin n_err++; $display("FAIL single_rf_wd: got %h want 00001234", wb.rf_wd); end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (wb.rf_we !== 1'b0) begin n_err++; $display("FAIL single_rf_we_drop: got %b want 0", wb.rf_we); end
    n_cmp++; if (wb.rf_rd !== 5'd5) begin n_err++; $display("FAIL single_rf_rd_hold: got %0d want 5", wb.rf_rd); end
    n_cmp++; if (wb.rf_wd !== 32'h1234) begin n_err++; $display("FAIL single_rf_wd_hold: got %h want 00001234", wb.rf_wd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad, bd, exp_d;
    logic [4:0]  exp_rd;
    logic        ga;
    @(negedge clk);
    ad = 32'hA000_0000; bd = 32'hB000_0000;
    wb.a_valid = 1'b1; wb.a_rd = 5'd3; wb.a_data = ad;
    wb.b_valid = 1'b1; wb.b_rd = 5'd4; wb.b_data = bd;
    for (int i = 0; i < 4; i++) begin
      #1;
      ga = ((i % 2) == 0);
      n_cmp++; if (wb.a_ready !== ga) begin n_err++; $display("FAIL b2b_a_ready[%0d]: got %b want %b", i, wb.a_ready, ga); end
      n_cmp++; if (wb.b_ready !== ~ga) begin n_err++; $display("FAIL b2b_b_ready[%0d]: got %b want %b", i, wb.b_ready, ~ga); end
      exp_rd = ga ? 5'd3 : 5'd4;
      exp_d  = ga ? ad : bd;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (wb.rf_we !== 1'b1) begin n_err++; $display("FAIL b2b_rf_we[%0d]: got %b want 1", i, wb.rf_we); end
      n_cmp++; if (wb.rf_rd !== exp_rd) begin n_err++; $display("FAIL b2b_rf_rd[%0d]: got %0d want %0d", i, wb.rf_rd, exp_rd); end
      n_cmp++; if (wb.rf_wd !== exp_d) begin n_err++; $display("FAIL b2b_rf_wd[%0d]: got %h want %h", i, wb.rf_wd, exp_d); end
      if (ga) begin ad = ad + 1; wb.a_data = ad; end
      else    begin bd = bd + 1; wb.b_data = bd; end
    end
    idle();
    @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (wb.rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_rf_we_end: got %b want 0", wb.rf_we); end
  endtask

  task automatic test_hazard();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    n_cmp++; if (haz_rd !== 1'b0) begin n_err++; $display("FAIL haz_rd_first: got %b want 0", haz_rd); end
    n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL haz_rs1_before: got %b want 0", haz_rs1); end
    @(posedge clk); @(negedge clk); iss_valid = 1'b0; iss_rd = '0; #1;
    n_cmp++; if (pend !== 32'h80) begin n_err++; $display("FAIL haz_pend7: got %h want 00000080", pend); end
    n_cmp++; if (haz_rs1 !== 1'b1) begin n_err++; $display("FAIL haz_rs1_pend: got %b want 1", haz_rs1); end
    n_cmp++; if (haz_rs2 !== 1'b1) begin n_err++; $display("FAIL haz_rs2_pend: got %b want 1", haz_rs2); end
    @(posedge clk); @(negedge clk);
    wb.a_valid = 1'b1; wb.a_rd = 5'd7; wb.a_data = 32'h0000_0077; #1;
    n_cmp++; if (wb.a_ready !== 1'b1) begin n_err++; $display("FAIL haz_wb_ready: got %b want 1", wb.a_ready); end
    n_cmp++; if (haz_rs1 !== 1'b1) begin n_err++; $display("FAIL haz_rs1_hs: got %b want 1", haz_rs1); end
    @(posedge clk); @(negedge clk); wb.a_valid = 1'b0; #1;
    n_cmp++; if (wb.rf_we !== 1'b1) begin n_err++; $display("FAIL haz_rf_we: got %b want 1", wb.rf_we); end
    n_cmp++; if (pend !== 32'h0) begin n_err++; $display("FAIL haz_pend_clr: got %h want 0", pend); end
`ifdef RF_WB_BYPASS_EN
    n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL haz_rs1_we: got %b want 0", haz_rs1); end
    n_cmp++; if (fwd1_hit !== 1'b1) begin n_err++; $display("FAIL fwd1_hit: got %b want 1", fwd1_hit); end
    n_cmp++; if (fwd1_data !== 32'h77) begin n_err++; $display("FAIL fwd1_data: got %h want 00000077", fwd1_data); end
    n_cmp++; if (fwd2_hit !== 1'b1) begin n_err++; $display("FAIL fwd2_hit: got %b want 1", fwd2_hit); end
`else
    n_cmp++; if (haz_rs1 !== 1'b1) begin n_err++; $display("FAIL haz_rs1_we: got %b want 1", haz_rs1); end
    n_cmp++; if (haz_rs2 !== 1'b1) begin n_err++; $display("FAIL haz_rs2_we: got %b want 1", haz_rs2); end
`endif
    @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL haz_rs1_after: got %b want 0", haz_rs1); end
    n_cmp++; if (haz_rs2 !== 1'b0) begin n_err++; $display("FAIL haz_rs2_after: got %b want 0", haz_rs2); end
    idle();
  endtask

  task automatic test_set_clear();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd9;
    @(posedge clk); @(negedge clk);
    wb.b_valid = 1'b1; wb.b_rd = 5'd9; wb.b_data = 32'h99; #1;
    n_cmp++; if (wb.b_ready !== 1'b1) begin n_err++; $display("FAIL sc_b_ready: got %b want 1", wb.b_ready); end
    n_cmp++; if (haz_rd !== 1'b1) begin n_err++; $display("FAIL sc_haz_rd: got %b want 1", haz_rd); end
    @(posedge clk); @(negedge clk); wb.b_valid = 1'b0; iss_rd = 5'd0; #1;
    n_cmp++; if (pend !== 32'h200) begin n_err++; $display("FAIL sc_pend_setwins: got %h want 00000200", pend); end
    n_cmp++; if (wb.rf_rd !== 5'd9) begin n_err++; $display("FAIL sc_rf_rd: got %0d want 9", wb.rf_rd); end
    n_cmp++; if (haz_rd !== 1'b0) begin n_err++; $display("FAIL sc_haz_rd_x0: got %b want 0", haz_rd); end
    @(posedge clk); @(negedge clk); iss_valid = 1'b0; #1;
    n_cmp++; if (pend !== 32'h200) begin n_err++; $display("FAIL sc_pend_x0: got %h want 00000200", pend); end
    idle();
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    wb.a_valid = 1'b1; wb.a_rd = 5'd0; wb.a_data = 32'hFFFF; iss_valid = 1'b1; iss_rd = 5'd0; #1;
    n_cmp++; if (wb.a_ready !== 1'b1) begin n_err++; $display("FAIL rd0_a_ready: got %b want 1", wb.a_ready); end
    @(posedge clk); @(negedge clk); idle();
    wb.a_valid = 1'b1; wb.a_rd = 5'd1; wb.b_valid = 1'b1; wb.b_rd = 5'd2; wb.b_data = 32'h22; #1;
    n_cmp++; if (wb.rf_we !== 1'b0) begin n_err++; $display("FAIL rd0_rf_we: got %b want 0", wb.rf_we); end
    n_cmp++; if (wb.rf_wd !== 32'hFFFF) begin n_err++; $display("FAIL rd0_rf_wd: got %h want 0000ffff", wb.rf_wd); end
    n_cmp++; if (pend !== 32'h0) begin n_err++; $display("FAIL rd0_pend: got %h want 0", pend); end
    n_cmp++; if (wb.a_ready !== 1'b0) begin n_err++; $display("FAIL rd0_rr_a: got %b want 0", wb.a_ready); end
    n_cmp++; if (wb.b_ready !== 1'b1) begin n_err++; $display("FAIL rd0_rr_b: got %b want 1", wb.b_ready); end
    @(posedge clk); @(negedge clk); idle(); #1;
    n_cmp++; if (wb.rf_rd !== 5'd2) begin n_err++; $display("FAIL rd0_next_rd: got %0d want 2", wb.rf_rd); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd6;
    @(posedge clk); @(negedge clk); iss_rd = 5'd8;
    @(posedge clk); @(negedge clk); iss_valid = 1'b0; iss_rd = '0;
    wb.a_valid = 1'b1; wb.a_rd = 5'd6; wb.a_data = 32'h66; #1;
    n_cmp++; if (pend !== 32'h140) begin n_err++; $display("FAIL rm_pend: got %h want 00000140", pend); end
    @(posedge clk); @(negedge clk); idle(); rst = 1'b1; #1;
    n_cmp++; if (wb.rf_we !== 1'b1) begin n_err++; $display("FAIL rm_rf_we_pre: got %b want 1", wb.rf_we); end
    @(posedge clk); @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (wb.rf_we !== 1'b0) begin n_err++; $display("FAIL rm_rf_we: got %b want 0", wb.rf_we); end
    n_cmp++; if (pend !== 32'h0) begin n_err++; $display("FAIL rm_pend_clr: got %h want 0", pend); end
    wb.a_valid = 1'b1; wb.a_rd = 5'd1; wb.b_valid = 1'b1; wb.b_rd = 5'd2; #1;
    n_cmp++; if (wb.a_ready !== 1'b1) begin n_err++; $display("FAIL rm_rr_a: got %b want 1", wb.a_ready); end
    n_cmp++; if (wb.b_ready !== 1'b0) begin n_err++; $display("FAIL rm_rr_b: got %b want 0", wb.b_ready); end
    @(posedge clk); @(negedge clk); idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_write();
    do_reset();
    test_back_to_back();
    test_hazard();
    test_set_clear();
    do_reset();
    test_rd_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
